// File: rtl/crc16_lfsr_unit.sv
// Byte-serial CRC generator/checker. Each accepted beat folds DW data bits
// (MSB first) into a WIDTH-bit remainder; the final remainder is presented
// with a hold-until-ack handshake. No reflection, no final XOR.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an SOF beat; non-SOF beats are consumed and dropped
// RUN   | frame in progress; SOF restarts the frame, EOF closes it
// DONE  | result pending on CRC_OUT/CRC_OK; input stalled until CRC_ACK
module crc16_lfsr_unit #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h1021,
    parameter logic [WIDTH-1:0] INIT  = 16'hFFFF,
    parameter int               DW    = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SOF,
    input  logic             EOF,
    input  logic [DW-1:0]    DIN,
    output logic             CRC_VALID,
    output logic [WIDTH-1:0] CRC_OUT,
    output logic             CRC_OK,
    input  logic             CRC_ACK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fold_seed;
    logic [WIDTH-1:0] rem_next;
    logic             beat_accept;

    // Fold all DW bits of one beat into the remainder, MSB of data first.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] seed,
                                              input logic [DW-1:0]    data);
        logic [WIDTH-1:0] r;
        logic             fb;
        r = seed;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = r[WIDTH-1] ^ data[i];
            r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // Ready depends on state only so upstream never sees a combinational loop.
    assign IN_READY = (state != S_DONE);

    // Next remainder: an SOF beat (or any beat seen from IDLE) starts from INIT.
    always_comb begin
        beat_accept = IN_VALID && IN_READY;
        fold_seed   = ((state == S_IDLE) || SOF) ? INIT : rem;
        rem_next    = fold(fold_seed, DIN);
    end

    // Frame sequencing, remainder update and registered result outputs.
    always_ff @(posedge CLK) begin
        if (!R) begin
            state     <= S_IDLE;
            rem       <= INIT;
            CRC_VALID <= 1'b0;
            CRC_OUT   <= '0;
            CRC_OK    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (beat_accept && SOF) begin
                        rem <= rem_next;
                        if (EOF) begin
                            state     <= S_DONE;
                            CRC_VALID <= 1'b1;
                            CRC_OUT   <= rem_next;
                            CRC_OK    <= (rem_next == '0);
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (beat_accept) begin
                        rem <= rem_next;
                        if (EOF) begin
                            state     <= S_DONE;
                            CRC_VALID <= 1'b1;
                            CRC_OUT   <= rem_next;
                            CRC_OK    <= (rem_next == '0);
                        end
                    end
                end
                S_DONE: begin
                    // CRC_OUT keeps the last result after the handshake.
                    if (CRC_ACK) begin
                        state     <= S_IDLE;
                        CRC_VALID <= 1'b0;
                        CRC_OK    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_lfsr_unit.sv
// Self-checking bench for crc16_lfsr_unit: directed frames plus random
// frames with random bubbles, compared against a table-driven CRC model.
module tb_crc16_lfsr_unit;

    logic        CLK;
    logic        R;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SOF;
    logic        EOF;
    logic [7:0]  DIN;
    logic        CRC_VALID;
    logic [15:0] CRC_OUT;
    logic        CRC_OK;
    logic        CRC_ACK;

    int          checks;
    int          errors;
    logic [15:0] crc_tbl [256];
    logic [7:0]  frame [$];
    logic [15:0] exp_crc;

    crc16_lfsr_unit dut (
        .CLK       (CLK),
        .R         (R),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SOF       (SOF),
        .EOF       (EOF),
        .DIN       (DIN),
        .CRC_VALID (CRC_VALID),
        .CRC_OUT   (CRC_OUT),
        .CRC_OK    (CRC_OK),
        .CRC_ACK   (CRC_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // CRC-CCITT (non-reflected) via a byte lookup table built by polynomial division.
    task automatic build_table();
        logic [15:0] v;
        for (int b = 0; b < 256; b++) begin
            v = 16'(b) << 8;
            for (int k = 0; k < 8; k++)
                v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
            crc_tbl[b] = v;
        end
    endtask

    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (frame[i])
            c = (c << 8) ^ crc_tbl[c[15:8] ^ frame[i]];
        return c;
    endfunction

    task automatic load_digits(input int n);
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(8'h31 + 8'(i));
    endtask

    // Sends the frame queue; gaps of 0..gap_max idle cycles carry random DIN.
    // with_eof=0 leaves the frame open (used for abort/reset scenarios).
    task automatic send_frame(input int gap_max, input bit with_eof);
        for (int i = 0; i < frame.size(); i++) begin
            int gaps;
            gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                IN_VALID = 1'b0;
                SOF      = 1'($urandom);
                EOF      = 1'($urandom);
                DIN      = 8'($urandom);
                tick();
            end
            chk("valid_low_mid_frame", 32'(CRC_VALID), 32'd0);
            IN_VALID = 1'b1;
            SOF      = (i == 0);
            EOF      = with_eof && (i == frame.size() - 1);
            DIN      = frame[i];
            tick();
        end
        IN_VALID = 1'b0;
        SOF      = 1'b0;
        EOF      = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] exp, input logic exp_ok);
        chk({tag, "_valid"}, 32'(CRC_VALID), 32'd1);
        chk({tag, "_out"},   32'(CRC_OUT),   32'(exp));
        chk({tag, "_ok"},    32'(CRC_OK),    32'(exp_ok));
    endtask

    task automatic do_ack(input logic [15:0] held);
        CRC_ACK = 1'b1;
        tick();
        CRC_ACK = 1'b0;
        chk("ack_valid_clr", 32'(CRC_VALID), 32'd0);
        chk("ack_ok_clr",    32'(CRC_OK),    32'd0);
        chk("ack_out_hold",  32'(CRC_OUT),   32'(held));
        chk("ack_ready",     32'(IN_READY),  32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        build_table();
        R        = 1'b0;
        IN_VALID = 1'b0;
        SOF      = 1'b0;
        EOF      = 1'b0;
        DIN      = 8'h00;
        CRC_ACK  = 1'b0;
        @(negedge CLK);
        tick();
        tick();
        chk("rst_ready", 32'(IN_READY),  32'd1);
        chk("rst_valid", 32'(CRC_VALID), 32'd0);
        chk("rst_out",   32'(CRC_OUT),   32'd0);
        chk("rst_ok",    32'(CRC_OK),    32'd0);
        R = 1'b1;
        tick();

        // Generate mode on the standard check string, then hold without ack.
        load_digits(9);
        exp_crc = ref_crc();
        chk("model_check_value", 32'(exp_crc), 32'h29B1);
        send_frame(0, 1'b1);
        check_result("gen", 16'h29B1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_result("gen_hold", 16'h29B1, 1'b0);
        end
        do_ack(16'h29B1);

        // Check mode: correct appended CRC, then a corrupted last byte.
        load_digits(9);
        frame.push_back(8'h29);
        frame.push_back(8'hB1);
        send_frame(0, 1'b1);
        check_result("chk_good", 16'h0000, 1'b1);
        do_ack(16'h0000);
        frame[10] = 8'hB0;
        exp_crc = ref_crc();
        send_frame(0, 1'b1);
        check_result("chk_bad", exp_crc, 1'b0);
        do_ack(exp_crc);

        // Backpressure: pending result, upstream keeps offering SOF+EOF beats.
        load_digits(9);
        send_frame(0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            IN_VALID = 1'b1;
            SOF      = 1'b1;
            EOF      = 1'b1;
            DIN      = 8'($urandom);
            chk("bp_ready_low", 32'(IN_READY), 32'd0);
            tick();
            check_result("bp_hold", 16'h29B1, 1'b0);
        end
        IN_VALID = 1'b0;
        SOF      = 1'b0;
        EOF      = 1'b0;
        do_ack(16'h29B1);
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(8'h3C);
        exp_crc = ref_crc();
        send_frame(0, 1'b1);
        check_result("bp_next", exp_crc, 1'b0);
        do_ack(exp_crc);

        // Junk beats in IDLE are dropped; "1234" is aborted by a fresh SOF.
        for (int c = 0; c < 4; c++) begin
            IN_VALID = 1'b1;
            SOF      = 1'b0;
            EOF      = 1'($urandom);
            DIN      = 8'($urandom);
            tick();
            chk("idle_junk_valid", 32'(CRC_VALID), 32'd0);
            chk("idle_junk_ready", 32'(IN_READY),  32'd1);
        end
        load_digits(4);
        send_frame(0, 1'b0);
        load_digits(9);
        send_frame(0, 1'b1);
        check_result("abort", 16'h29B1, 1'b0);
        do_ack(16'h29B1);

        // Bubbles on the standard string.
        load_digits(9);
        send_frame(3, 1'b1);
        check_result("bubbles", 16'h29B1, 1'b0);
        do_ack(16'h29B1);

        // Random frames with random gaps, generate and check mode.
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(12, 1);
            frame.delete();
            for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
            exp_crc = ref_crc();
            send_frame(3, 1'b1);
            check_result("rand_gen", exp_crc, (exp_crc == 16'h0000));
            do_ack(exp_crc);
            frame.push_back(exp_crc[15:8]);
            frame.push_back(exp_crc[7:0]);
            send_frame(2, 1'b1);
            check_result("rand_chk", 16'h0000, 1'b1);
            do_ack(16'h0000);
        end

        // Reset mid-frame, then a full frame.
        load_digits(5);
        send_frame(0, 1'b0);
        R = 1'b0;
        tick();
        R = 1'b1;
        chk("midrst_valid", 32'(CRC_VALID), 32'd0);
        chk("midrst_out",   32'(CRC_OUT),   32'd0);
        chk("midrst_ready", 32'(IN_READY),  32'd1);
        load_digits(9);
        send_frame(1, 1'b1);
        check_result("midrst_frame", 16'h29B1, 1'b0);

        // Reset while a result is pending.
        R = 1'b0;
        tick();
        R = 1'b1;
        chk("donerst_valid", 32'(CRC_VALID), 32'd0);
        chk("donerst_out",   32'(CRC_OUT),   32'd0);
        chk("donerst_ok",    32'(CRC_OK),    32'd0);
        chk("donerst_ready", 32'(IN_READY),  32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
